// File: rtl/alu_mdu.sv
// Execute-stage ALU with valid/ready handshake, registered result and
// iterative unsigned multiply/divide writing architectural HI/LO registers.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucont,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf, slt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  assign sum  = a + b;
  assign diff = a - b;
  // Differing signs decide SLT directly; equal signs cannot overflow the difference.
  assign slt  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alucont)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // work_q holds {partial product, multiplier} during MUL and {remainder, quotient} during DIV.
  assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, op_q} : '0);
  assign mul_next  = {mul_sum, work_q[WIDTH-1:1]};
  assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, op_q};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - op_q) : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, work_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alucont == OP_MULTU) begin
            op_d    = a;
            work_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = CW'(WIDTH);
            state_d = MUL;
          end else if (alucont == OP_DIVU && b != '0) begin
            op_d    = b;
            work_d  = {{WIDTH{1'b0}}, a};
            cnt_d   = CW'(WIDTH);
            state_d = DIV;
          end else if (alucont == OP_DIVU) begin
            hi_d     = a;
            lo_d     = '1;
            result_d = '1;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        work_d = mul_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d     = mul_next[2*WIDTH-1:WIDTH];
          lo_d     = mul_next[WIDTH-1:0];
          result_d = mul_next[WIDTH-1:0];
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DIV: begin
        work_d = div_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          lo_d     = div_next[WIDTH-1:0];
          hi_d     = div_next[2*WIDTH-1:WIDTH];
          result_d = div_next[WIDTH-1:0];
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized scoreboard bench for alu_mdu: a driver pushes reference-model
// expectations, a monitor pops and compares whenever a result is handed off.
module tb_alu_mdu;

  localparam int W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, zero, ovf;
  logic [W-1:0] a, b, result;
  logic [3:0]   alucont;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, zero8, ovf8;
  logic [7:0] a8, b8, result8;
  logic [3:0] alucont8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   lat_obs = 0;
  bit   seen = 0;
  bit   rand_bp = 0;
  logic [W-1:0] hi_m, lo_m;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alucont(alucont), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alucont(alucont8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .zero(zero8), .ovf(ovf8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the architectural HI/LO state.
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t e);
    longint s;
    logic [63:0] p;
    e.res = '0;
    e.ovf = 1'b0;
    e.lat = 0;
    e.acc = 0;
    case (op)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_ADD, OP_SUB: begin
        s = (op == OP_ADD) ? longint'($signed(x)) + longint'($signed(y))
                           : longint'($signed(x)) - longint'($signed(y));
        e.res = s[W-1:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
      OP_MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        hi_m = p[63:32];
        lo_m = p[31:0];
        e.res = lo_m;
        e.lat = W;
      end
      OP_DIVU: begin
        if (y == 0) begin
          hi_m = x;
          lo_m = '1;
        end else begin
          lo_m = x / y;
          hi_m = x % y;
          e.lat = W;
        end
        e.res = lo_m;
      end
      OP_MFHI: e.res = hi_m;
      OP_MFLO: e.res = lo_m;
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
  endtask

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("[TB] FAIL ready_timeout: in_ready got 0 expected 1");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] in_ready never asserted");
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    waitReady();
    in_valid = 1'b1;
    alucont  = op;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    model(op, x, y, e);
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alucont  = 4'($urandom);
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] exp_res, input int exp_lat);
    int n = 0;
    @(negedge clk);
    in_valid8 = 1'b1;
    alucont8  = op;
    a8        = x;
    b8        = y;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("w8_latency", 64'(n), 64'(exp_lat));
    checkOutput("w8_result", 64'(result8), 64'(exp_res));
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures first-valid latency, compares on each completed handoff.
  always @(negedge clk) begin
    if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: result %0h with empty scoreboard", result);
      end else begin
        lat_obs = cyc - sb[0].acc;
      end
    end
    if (out_valid && out_ready) begin
      seen = 1'b0;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checkOutput("result", 64'(result), 64'(mon_e.res));
        checkOutput("zero", 64'(zero), 64'(mon_e.zero));
        checkOutput("ovf", 64'(ovf), 64'(mon_e.ovf));
        checkOutput("latency", 64'(lat_obs), 64'(mon_e.lat));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_result"}, 64'(result), 64'd0);
    checkOutput({tag, "_zero"}, 64'(zero), 64'd1);
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    logic [3:0] ops [11];
    int n;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MULTU, OP_DIVU,
            OP_MFHI, OP_MFLO, 4'b0011, 4'b1111};
    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; alucont = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; alucont8 = '0; out_ready8 = 1'b1;
    hi_m = '0;
    lo_m = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;

    applyStimulus(OP_ADD, 33, 23);
    applyStimulus(OP_SUB, 23, 33);
    applyStimulus(OP_SLT, 23, 33);
    applyStimulus(OP_ADD, 32'h7FFFFFFF, 1);
    applyStimulus(OP_SUB, 32'h80000000, 1);
    applyStimulus(OP_SLT, 32'h80000000, 32'h7FFFFFFF);
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 2);
    applyStimulus(OP_MFHI, 0, 0);
    applyStimulus(OP_MFLO, 0, 0);
    applyStimulus(OP_DIVU, 100, 7);
    applyStimulus(OP_MFHI, 0, 0);
    applyStimulus(OP_DIVU, 5, 0);
    applyStimulus(OP_MFHI, 0, 0);
    applyStimulus(4'b1100, 3, 4);

    // Backpressure: result must stay put and new requests must be refused.
    waitReady();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(OP_AND, 32'hF0F0, 32'hFF00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_result", 64'(result), 64'h0000F000);
      in_valid = 1'b1;
      alucont  = OP_OR;
      a        = $urandom;
      b        = $urandom;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply: no HI/LO update may survive.
    waitReady();
    in_valid = 1'b1;
    alucont  = OP_MULTU;
    a        = 32'h12345678;
    b        = 32'h9ABCDEF1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("midreset");
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    applyStimulus(OP_MFHI, 0, 0);
    applyStimulus(OP_MFLO, 0, 0);
    applyStimulus(OP_ADD, 1, 1);

    run8(OP_DIVU, 8'hFF, 8'h10, 8'h0F, 8);
    run8(OP_MFHI, 8'h00, 8'h00, 8'h0F, 0);
    run8(OP_MFLO, 8'h00, 8'h00, 8'h0F, 0);

    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 0;
        1: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      applyStimulus(ops[$urandom_range(0, 10)], x, y);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
